// File: rtl/x_clkdll_pkg.sv
// x_clkdll_pkg
//   Shared types and constants for the CLKDLL lock-monitor slice.
//   - mon_state_t : lock-monitor FSM states
//   - SYNC_STAGES : flop depth used to bring asynchronous CLKDLL signals
//                   into the system clock domain
package x_clkdll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_LOST
  } mon_state_t;

  localparam int unsigned SYNC_STAGES = 2;

endpackage

// File: rtl/x_clkdll_edge_sync.sv
// x_clkdll_edge_sync
//   Multi-flop synchronizer followed by a rising-edge detector, for any
//   CLKDLL-side signal that is asynchronous to clk.
// Ports:
//   clk   in  system clock (rising edge)
//   rst_n in  asynchronous active-low reset, clears every flop
//   din   in  asynchronous input
//   rise  out one-cycle pulse when the synchronized input goes 0 -> 1
module x_clkdll_edge_sync
  import x_clkdll_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              dly_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      dly_q  <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~dly_q;

endmodule

// File: rtl/x_clkdll_lock_monitor.sv
// x_clkdll_lock_monitor
//   Measures the period of a CLKDLL output clock in system-clock cycles,
//   qualifies it as stable and reports lock, loss of lock and loss of clock.
// Ports:
//   CLK          in  system clock
//   RST_N        in  asynchronous active-low reset
//   CLKMON       in  monitored clock (asynchronous, period >= 4 CLK)
//   EN           in  monitor enable; low forces IDLE
//   CLR          in  pulse clearing the sticky LOSS flag
//   LOCKED       out monitored clock is stable
//   LOSS         out sticky loss-of-lock / loss-of-clock flag
//   PERIOD       out last measured period in CLK cycles
//   PERIOD_VALID out one-cycle pulse when PERIOD updates
module x_clkdll_lock_monitor
  import x_clkdll_pkg::*;
#(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned LOCK_CYCLES = 8,
  parameter int unsigned TOL         = 2,
  parameter int unsigned MAX_PERIOD  = 1000
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             CLKMON,
  input  logic             EN,
  input  logic             CLR,
  output logic             LOCKED,
  output logic             LOSS,
  output logic [CNT_W-1:0] PERIOD,
  output logic             PERIOD_VALID
);

  localparam int unsigned      STB_W    = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PERIOD);
  localparam logic [STB_W-1:0] LOCK_CNT = STB_W'(LOCK_CYCLES);
  localparam logic [CNT_W:0]   TOL_D    = (CNT_W + 1)'(TOL);

  mon_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] ref_q, ref_d;
  logic [STB_W-1:0] stable_q, stable_d;
  logic             first_q, first_d;
  logic             mon_edge;
  logic             timeout;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             measure;
  logic             loss_evt;

  x_clkdll_edge_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (CLKMON),
    .rise  (mon_edge)
  );

  // Edge wins over a simultaneous saturation.
  assign timeout = (cnt_q == MAX_CNT) && !mon_edge;

  always_comb begin
    if ({1'b0, cnt_q} >= {1'b0, ref_q}) diff = {1'b0, cnt_q} - {1'b0, ref_q};
    else                                diff = {1'b0, ref_q} - {1'b0, cnt_q};
  end

  assign in_tol = (diff <= TOL_D);

  always_comb begin
    state_d  = state_q;
    ref_d    = ref_q;
    stable_d = stable_q;
    first_d  = first_q;
    measure  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ref_d    = '0;
        stable_d = '0;
        first_d  = 1'b1;
        state_d  = ST_ARM;
      end
      ST_ARM: begin
        first_d = 1'b1;
        if (mon_edge)     state_d = ST_ACQUIRE;
        else if (timeout) state_d = ST_LOST;
      end
      ST_ACQUIRE: begin
        if (mon_edge) begin
          measure = 1'b1;
          ref_d   = cnt_q;
          if (first_q) begin
            first_d  = 1'b0;
            stable_d = '0;
          end else if (in_tol) begin
            stable_d = stable_q + STB_W'(1);
            if (stable_d == LOCK_CNT) state_d = ST_LOCKED;
          end else begin
            stable_d = '0;
          end
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOCKED: begin
        // Reference frozen at lock time so slow drift accumulates.
        if (mon_edge) begin
          measure = 1'b1;
          if (!in_tol) state_d = ST_LOST;
        end else if (timeout) begin
          state_d = ST_LOST;
        end
      end
      ST_LOST: begin
        stable_d = '0;
        first_d  = 1'b1;
        state_d  = ST_ARM;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!EN) begin
      state_d = ST_IDLE;
      measure = 1'b0;
    end
  end

  assign loss_evt = (state_d == ST_LOST);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ref_q        <= '0;
      stable_q     <= '0;
      first_q      <= 1'b1;
      LOCKED       <= 1'b0;
      LOSS         <= 1'b0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
    end else begin
      state_q  <= state_d;
      ref_q    <= ref_d;
      stable_q <= stable_d;
      first_q  <= first_d;

      if (state_q == ST_IDLE || state_q == ST_LOST) cnt_q <= '0;
      else if (mon_edge)                            cnt_q <= CNT_W'(1);
      else if (cnt_q != MAX_CNT)                    cnt_q <= cnt_q + CNT_W'(1);

      PERIOD_VALID <= measure;
      if (measure) PERIOD <= cnt_q;

      LOCKED <= (state_d == ST_LOCKED);

      // A loss event in the same cycle as CLR keeps LOSS set.
      if (loss_evt) LOSS <= 1'b1;
      else if (CLR) LOSS <= 1'b0;
    end
  end

endmodule

// File: tb/tb_x_clkdll_lock_monitor.sv
module tb_x_clkdll_lock_monitor;

  localparam int unsigned CNT_W       = 16;
  localparam int unsigned LOCK_CYCLES = 4;
  localparam int unsigned TOL         = 1;
  localparam int unsigned MAX_PERIOD  = 50;

  logic             clk    = 1'b0;
  logic             rst_n  = 1'b0;
  logic             clkmon = 1'b0;
  logic             en     = 1'b0;
  logic             clr    = 1'b0;
  logic             locked;
  logic             loss;
  logic [CNT_W-1:0] period;
  logic             period_valid;

  x_clkdll_lock_monitor #(
    .CNT_W       (CNT_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .TOL         (TOL),
    .MAX_PERIOD  (MAX_PERIOD)
  ) dut (
    .CLK          (clk),
    .RST_N        (rst_n),
    .CLKMON       (clkmon),
    .EN           (en),
    .CLR          (clr),
    .LOCKED       (locked),
    .LOSS         (loss),
    .PERIOD       (period),
    .PERIOD_VALID (period_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Edge-level reference model: one call per driven CLKMON rising edge.
  typedef struct packed {
    int p;
    bit lk;
    bit ls;
  } meas_t;

  meas_t exp_q[$];
  bit    m_wait   = 1'b1;
  bit    m_locked = 1'b0;
  bit    m_loss   = 1'b0;
  int    ref_p    = -1;
  int    run      = 0;
  int    last_rise = 0;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic model_edge(input int r);
    int p;
    meas_t m;
    if (m_wait) begin
      m_wait = 1'b0;
      ref_p  = -1;
    end else begin
      p = r - last_rise;
      if (m_locked) begin
        if (absdiff(p, ref_p) > int'(TOL)) begin
          m_locked = 1'b0;
          m_loss   = 1'b1;
          m_wait   = 1'b1;
        end
      end else if (ref_p < 0) begin
        ref_p = p;
        run   = 0;
      end else begin
        if (absdiff(p, ref_p) <= int'(TOL)) run++;
        else                                run = 0;
        ref_p = p;
        if (run >= int'(LOCK_CYCLES)) m_locked = 1'b1;
      end
      m.p  = p;
      m.lk = m_locked;
      m.ls = m_loss;
      exp_q.push_back(m);
    end
    last_rise = r;
  endtask

  always @(negedge clk) begin
    if (rst_n && period_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_valid", {31'b0, period_valid}, 32'd0);
      end else begin
        meas_t e;
        e = exp_q.pop_front();
        check("period", {16'b0, period}, e.p);
        check("locked_at_meas", {31'b0, locked}, {31'b0, e.lk});
        check("loss_at_meas", {31'b0, loss}, {31'b0, e.ls});
      end
    end
  end

  // All stimulus tasks start and end on a falling CLK edge.
  task automatic mon_pulse(input int p);
    model_edge(cyc);
    clkmon = 1'b1;
    repeat (p / 2) @(negedge clk);
    clkmon = 1'b0;
    repeat (p - p / 2) @(negedge clk);
  endtask

  task automatic enable_fresh();
    en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    en       = 1'b1;
    m_wait   = 1'b1;
    m_locked = 1'b0;
    ref_p    = -1;
    run      = 0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr    = 1'b0;
    m_loss = 1'b0;
  endtask

  task automatic settle();
    repeat (6) @(negedge clk);
    check("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int jit[13] = '{10, 11, 9, 10, 11, 10, 11, 10, 11, 12, 10, 12, 11};

  initial begin
    int t0, t1, waited, elapsed, base, p, r;

    repeat (3) @(negedge clk);
    check("rst_locked", {31'b0, locked}, 32'd0);
    check("rst_loss", {31'b0, loss}, 32'd0);
    check("rst_period", {16'b0, period}, 32'd0);
    check("rst_valid", {31'b0, period_valid}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Steady lock at period 10
    enable_fresh();
    repeat (8) mon_pulse(10);
    settle();
    check("steady_locked", {31'b0, locked}, 32'd1);
    check("steady_loss", {31'b0, loss}, 32'd0);

    // Jitter within tolerance
    enable_fresh();
    foreach (jit[i]) mon_pulse(jit[i]);
    settle();
    check("jitter_locked", {31'b0, locked}, 32'd1);

    // EN drop while locked
    en = 1'b0;
    m_locked = 1'b0;
    @(negedge clk);
    check("endrop_locked", {31'b0, locked}, 32'd0);
    check("endrop_loss", {31'b0, loss}, 32'd0);

    // Period jump after lock, then re-lock at the new period
    enable_fresh();
    repeat (7) mon_pulse(10);
    repeat (8) mon_pulse(13);
    settle();
    check("jump_relock", {31'b0, locked}, 32'd1);
    check("jump_loss", {31'b0, loss}, 32'd1);
    pulse_clr();
    check("jump_clr", {31'b0, loss}, 32'd0);

    // Stopped clock
    enable_fresh();
    repeat (7) mon_pulse(10);
    check("stop_pre_locked", {31'b0, locked}, 32'd1);
    waited = 0;
    while (locked && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    elapsed = cyc - last_rise;
    check("stop_locked", {31'b0, locked}, 32'd0);
    check($sformatf("stop_latency_window(elapsed=%0d)", elapsed),
          (elapsed >= 51 && elapsed <= 55) ? 32'd1 : 32'd0, 32'd1);
    check("stop_loss", {31'b0, loss}, 32'd1);
    m_locked = 1'b0;
    m_wait   = 1'b1;
    t0 = cyc;
    pulse_clr();
    check("stop_clr", {31'b0, loss}, 32'd0);

    // Repeated timeout while armed with no clock
    waited = 0;
    while (!loss && waited < 80) begin
      @(negedge clk);
      waited++;
    end
    check("arm_timeout_period", cyc - t0, 32'd52);
    t1 = cyc;
    pulse_clr();
    check("arm_clr", {31'b0, loss}, 32'd0);

    // CLR in the same cycle as the next timeout
    while (cyc < t1 + 51) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_collision", {31'b0, loss}, 32'd1);
    pulse_clr();

    // Reset mid-acquire
    enable_fresh();
    repeat (4) mon_pulse(10);
    check("pre_rst_period", {16'b0, period}, 32'd10);
    rst_n = 1'b0;
    #1;
    check("midrst_locked", {31'b0, locked}, 32'd0);
    check("midrst_loss", {31'b0, loss}, 32'd0);
    check("midrst_period", {16'b0, period}, 32'd0);
    check("midrst_valid", {31'b0, period_valid}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    m_loss   = 1'b0;
    m_locked = 1'b0;
    m_wait   = 1'b1;
    @(negedge clk);

    // Randomized periods with jitter and occasional jumps
    for (int round = 0; round < 6; round++) begin
      pulse_clr();
      enable_fresh();
      base = int'($urandom_range(6, 20));
      for (int k = 0; k < 14; k++) begin
        r = int'($urandom_range(0, 15));
        p = base;
        if (r < 10)      p = base + int'($urandom_range(0, 2)) - 1;
        else if (r < 12) p = base + (($urandom_range(0, 1) == 0) ? 1 : -1) * int'($urandom_range(2, 4));
        if (p < 4)  p = 4;
        if (p > 30) p = 30;
        mon_pulse(p);
      end
      settle();
      check("rand_locked", {31'b0, locked}, {31'b0, m_locked});
      check("rand_loss", {31'b0, loss}, {31'b0, m_loss});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
